// File: rtl/ife_pkg.sv
// Shared widths, types and slot extraction for the instruction block unpacker.
// A block carries four 32-bit instructions, and slot 0 sits in the most significant word.
package ife_pkg;

  localparam int INSTR_W = 32;
  localparam int SLOTS   = 4;
  localparam int BLOCK_W = INSTR_W * SLOTS;

  typedef logic [1:0]       slot_idx_t;
  typedef logic [SLOTS-1:0] slot_mask_t;

  function automatic logic [INSTR_W-1:0] block_slot(input logic [BLOCK_W-1:0] block,
                                                    input slot_idx_t          i);
    return block[BLOCK_W-1-INSTR_W*int'(i) -: INSTR_W];
  endfunction

endpackage

// File: rtl/instr_block_unpacker_block_fifo.sv
// Generic synchronous FIFO with DEPTH entries and flush. Data is readable in the cycle after a push.
// A push is dropped when the FIFO is full, and a pop is dropped when it is empty. full is a registered count compare.
module block_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_ok && !pop_ok)      cnt_d = cnt_q + CNT_W'(1);
      else if (!push_ok && pop_ok) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage has no reset because the count gates every read of it.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/instr_block_unpacker.sv
// Buffers 4-instruction blocks and issues one non-zero instruction per cycle to decode. The first slot appears 1 cycle after accept.
// block_ready_out is the registered not-full flag, gated low during rst and flush. Outputs hold while decode stalls.
module instr_block_unpacker
  import ife_pkg::*;
#(
  parameter int ID_W      = 7,
  parameter int DEPTH     = 2,
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               block_valid_in,
  output logic               block_ready_out,
  input  logic [BLOCK_W-1:0] block_data_in,
  input  logic [ID_W-1:0]    block_id_in,
  input  logic               flush_in,
  output logic               instr_valid_out,
  input  logic               instr_ready_in,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ID_W-1:0]    instr_id_out,
  output logic [1:0]         instr_slot_out,
  output logic               instr_last_out
);

  localparam int ENTRY_W = BLOCK_W + ID_W + SLOTS;

  logic [ENTRY_W-1:0] fifo_din, fifo_dout;
  logic               fifo_full, fifo_empty;
  logic [BLOCK_W-1:0] head_data;
  logic [ID_W-1:0]    head_id;
  slot_mask_t         head_mask, in_mask;
  slot_idx_t          slot_ptr_q, slot_ptr_d, head_slot;
  logic               head_last, head_found, accept, issue_fire, pop;

  always_comb begin
    in_mask = '1;
    if (SKIP_ZERO) begin
      for (int i = 0; i < SLOTS; i++) in_mask[i] = (block_slot(block_data_in, slot_idx_t'(i)) != '0);
    end
  end

  assign block_ready_out = !rst && !flush_in && !fifo_full;
  assign accept          = block_valid_in && block_ready_out;
  assign fifo_din        = {block_data_in, block_id_in, in_mask};
  assign {head_data, head_id, head_mask} = fifo_dout;

  block_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush_in),
    .push  (accept && (in_mask != '0)),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The head slot is the first live slot at or after the pointer. A slot is the last one when no live slot follows it.
  always_comb begin
    head_found = 1'b0;
    head_slot  = '0;
    head_last  = 1'b1;
    for (int i = 0; i < SLOTS; i++) begin
      if (!head_found && (i >= int'(slot_ptr_q)) && head_mask[i]) begin
        head_found = 1'b1;
        head_slot  = slot_idx_t'(i);
      end
    end
    for (int i = 0; i < SLOTS; i++) begin
      if ((i > int'(head_slot)) && head_mask[i]) head_last = 1'b0;
    end
  end

  assign instr_valid_out = !rst && !fifo_empty;
  assign issue_fire      = instr_valid_out && instr_ready_in && !flush_in;
  assign pop             = issue_fire && head_last;
  assign instr_out       = instr_valid_out ? block_slot(head_data, head_slot) : '0;
  assign instr_id_out    = instr_valid_out ? head_id : '0;
  assign instr_slot_out  = instr_valid_out ? head_slot : '0;
  assign instr_last_out  = instr_valid_out && head_last;

  always_comb begin
    slot_ptr_d = slot_ptr_q;
    if (flush_in)        slot_ptr_d = '0;
    else if (issue_fire) slot_ptr_d = head_last ? slot_idx_t'(0) : head_slot + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) slot_ptr_q <= '0;
    else     slot_ptr_q <= slot_ptr_d;
  end

endmodule

// File: tb/tb_instr_block_unpacker.sv
// Directed checks of the unpacker: a per-cycle vector table followed by backpressure and flush sequences.
module tb_instr_block_unpacker;

  logic         clk = 1'b0;
  logic         rst;
  logic         block_valid_in;
  logic         block_ready_out;
  logic [127:0] block_data_in;
  logic [6:0]   block_id_in;
  logic         flush_in;
  logic         instr_valid_out;
  logic         instr_ready_in;
  logic [31:0]  instr_out;
  logic [6:0]   instr_id_out;
  logic [1:0]   instr_slot_out;
  logic         instr_last_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_block_unpacker dut (
    .clk            (clk),
    .rst            (rst),
    .block_valid_in (block_valid_in),
    .block_ready_out(block_ready_out),
    .block_data_in  (block_data_in),
    .block_id_in    (block_id_in),
    .flush_in       (flush_in),
    .instr_valid_out(instr_valid_out),
    .instr_ready_in (instr_ready_in),
    .instr_out      (instr_out),
    .instr_id_out   (instr_id_out),
    .instr_slot_out (instr_slot_out),
    .instr_last_out (instr_last_out)
  );

  localparam logic [127:0] BLK_A  = {32'h00500513, 32'h00520293, 32'h00600593, 32'h00628313};
  localparam logic [127:0] BLK_B  = {32'h00500513, 32'h00500513, 32'h00600593, 32'h00600593};
  localparam logic [127:0] BLK_Z  = {32'h00500513, 32'h00000000, 32'h00000000, 32'h00600593};
  localparam logic [127:0] BLK_ZZ = 128'h0;

  typedef struct {
    logic         rst;
    logic         bv;
    logic [127:0] bd;
    logic [6:0]   bi;
    logic         fl;
    logic         rd;
    logic         e_brdy;
    logic         e_vld;
    logic [31:0]  e_ins;
    logic [6:0]   e_id;
    logic [1:0]   e_slot;
    logic         e_last;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic bv, input logic [127:0] bd, input logic [6:0] bi,
                              input logic fl, input logic rd, input logic eb, input logic ev,
                              input logic [31:0] ei, input logic [6:0] eid, input logic [1:0] es,
                              input logic el);
    vec_t v;
    v.rst = r;  v.bv = bv;  v.bd = bd;  v.bi = bi;  v.fl = fl;  v.rd = rd;
    v.e_brdy = eb;  v.e_vld = ev;  v.e_ins = ei;  v.e_id = eid;  v.e_slot = es;  v.e_last = el;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic exp_out(input string tag, input logic eb, input logic ev, input logic [31:0] ei,
                         input logic [6:0] eid, input logic [1:0] es, input logic el);
    chk({tag, " block_ready"}, 32'(block_ready_out), 32'(eb));
    chk({tag, " instr_valid"}, 32'(instr_valid_out), 32'(ev));
    chk({tag, " instr"},       instr_out,            ei);
    chk({tag, " id"},          32'(instr_id_out),    32'(eid));
    chk({tag, " slot"},        32'(instr_slot_out),  32'(es));
    chk({tag, " last"},        32'(instr_last_out),  32'(el));
  endtask

  task automatic drive(input logic bv, input logic [127:0] bd, input logic [6:0] bi,
                       input logic fl, input logic rd);
    block_valid_in = bv;
    block_data_in  = bd;
    block_id_in    = bi;
    flush_in       = fl;
    instr_ready_in = rd;
  endtask

  // Inputs change 1 time unit after a rising edge, and outputs are sampled 4 units later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);

    // Reset state, then a single block issued one slot per cycle.
    vecs.push_back(mk(1, 0, '0,    0, 0, 1, 0, 0, 32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 1, BLK_A, 1, 0, 1, 1, 0, 32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 0, '0,    0, 0, 1, 1, 1, 32'h00500513, 1, 0, 0));
    vecs.push_back(mk(0, 0, '0,    0, 0, 1, 1, 1, 32'h00520293, 1, 1, 0));
    vecs.push_back(mk(0, 0, '0,    0, 0, 1, 1, 1, 32'h00600593, 1, 2, 0));
    vecs.push_back(mk(0, 0, '0,    0, 0, 1, 1, 1, 32'h00628313, 1, 3, 1));
    vecs.push_back(mk(0, 0, '0,    0, 0, 1, 1, 0, 32'h0,        0, 0, 0));
    // Back-to-back blocks: eight issue cycles with no bubble. The FIFO is full while both blocks are held.
    vecs.push_back(mk(0, 1, BLK_A, 1, 0, 1, 1, 0, 32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 1, BLK_B, 2, 0, 1, 1, 1, 32'h00500513, 1, 0, 0));
    vecs.push_back(mk(0, 0, '0,    0, 0, 1, 0, 1, 32'h00520293, 1, 1, 0));
    vecs.push_back(mk(0, 0, '0,    0, 0, 1, 0, 1, 32'h00600593, 1, 2, 0));
    vecs.push_back(mk(0, 0, '0,    0, 0, 1, 0, 1, 32'h00628313, 1, 3, 1));
    vecs.push_back(mk(0, 0, '0,    0, 0, 1, 1, 1, 32'h00500513, 2, 0, 0));
    vecs.push_back(mk(0, 0, '0,    0, 0, 1, 1, 1, 32'h00500513, 2, 1, 0));
    vecs.push_back(mk(0, 0, '0,    0, 0, 1, 1, 1, 32'h00600593, 2, 2, 0));
    vecs.push_back(mk(0, 0, '0,    0, 0, 1, 1, 1, 32'h00600593, 2, 3, 1));
    vecs.push_back(mk(0, 0, '0,    0, 0, 1, 1, 0, 32'h0,        0, 0, 0));
    // Zero skip: only slots 0 and 3 are issued. The all-zero block is accepted and never appears.
    vecs.push_back(mk(0, 1, BLK_Z,  3, 0, 1, 1, 0, 32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 1, BLK_ZZ, 4, 0, 1, 1, 1, 32'h00500513, 3, 0, 0));
    vecs.push_back(mk(0, 0, '0,     0, 0, 1, 1, 1, 32'h00600593, 3, 3, 1));
    vecs.push_back(mk(0, 0, '0,     0, 0, 1, 1, 0, 32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 0, '0,     0, 0, 1, 1, 0, 32'h0,        0, 0, 0));
    // rst pulsed mid-block: outputs are 0 during the pulse, and nothing stale is issued afterwards.
    vecs.push_back(mk(0, 1, BLK_A, 5, 0, 1, 1, 0, 32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 0, '0,    0, 0, 1, 1, 1, 32'h00500513, 5, 0, 0));
    vecs.push_back(mk(1, 0, '0,    0, 0, 1, 0, 0, 32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 0, '0,    0, 0, 1, 1, 0, 32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 0, '0,    0, 0, 1, 1, 0, 32'h0,        0, 0, 0));

    next_cycle();
    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst;
      drive(vecs[i].bv, vecs[i].bd, vecs[i].bi, vecs[i].fl, vecs[i].rd);
      #4;
      exp_out($sformatf("vec%0d", i), vecs[i].e_brdy, vecs[i].e_vld, vecs[i].e_ins,
              vecs[i].e_id, vecs[i].e_slot, vecs[i].e_last);
      next_cycle();
    end

    // Backpressure: decode stalls for 5 cycles while three blocks are offered.
    drive(1'b1, BLK_A, 7'd1, 1'b0, 1'b1);
    #4; exp_out("bp accept A", 1, 0, 32'h0, 0, 0, 0);
    next_cycle();
    drive(1'b1, BLK_B, 7'd2, 1'b0, 1'b1);
    #4; exp_out("bp accept B", 1, 1, 32'h00500513, 1, 0, 0);
    next_cycle();
    drive(1'b1, BLK_Z, 7'd3, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      #4; exp_out($sformatf("bp stall%0d", c), 0, 1, 32'h00520293, 1, 1, 0);
      next_cycle();
    end
    instr_ready_in = 1'b1;
    #4; exp_out("bp resume s1", 0, 1, 32'h00520293, 1, 1, 0);
    next_cycle();
    #4; exp_out("bp s2", 0, 1, 32'h00600593, 1, 2, 0);
    next_cycle();
    // The pop edge of A cannot admit the third block in the same edge.
    #4; exp_out("bp A last", 0, 1, 32'h00628313, 1, 3, 1);
    next_cycle();
    #4; exp_out("bp third accepted", 1, 1, 32'h00500513, 2, 0, 0);
    next_cycle();
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    #4; exp_out("bp B s1", 0, 1, 32'h00500513, 2, 1, 0);
    next_cycle();
    #4; exp_out("bp B s2", 0, 1, 32'h00600593, 2, 2, 0);
    next_cycle();
    #4; exp_out("bp B s3", 0, 1, 32'h00600593, 2, 3, 1);
    next_cycle();
    #4; exp_out("bp Z s0", 1, 1, 32'h00500513, 3, 0, 0);
    next_cycle();
    #4; exp_out("bp Z s3", 1, 1, 32'h00600593, 3, 3, 1);
    next_cycle();
    #4; exp_out("bp drained", 1, 0, 32'h0, 0, 0, 0);
    next_cycle();

    // Flush on the second instruction while another block is offered.
    drive(1'b1, BLK_A, 7'd9, 1'b0, 1'b1);
    #4; exp_out("fl accept", 1, 0, 32'h0, 0, 0, 0);
    next_cycle();
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    #4; exp_out("fl s0", 1, 1, 32'h00500513, 9, 0, 0);
    next_cycle();
    drive(1'b1, BLK_B, 7'd10, 1'b1, 1'b1);
    #4; exp_out("fl cycle", 0, 1, 32'h00520293, 9, 1, 0);
    next_cycle();
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    #4; exp_out("fl after", 1, 0, 32'h0, 0, 0, 0);
    next_cycle();
    #4; exp_out("fl offered dropped", 1, 0, 32'h0, 0, 0, 0);
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
